// File: rtl/acc16_flag_stage.sv
// Registered accumulate stage with ALU flags. Optional macro ACC16_STICKY_OVF_EN makes overflow sticky.
// Latency 1 cycle. Backpressure: in_ready = ~out_valid | out_ready (single result register).
module acc16_flag_stage #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic             out_sign,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_parity,
    output logic             out_overflow,
    output logic [CNT_W-1:0] out_cnt
);

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ACC   = 2'b01,
        OP_PASS  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             sign_q, sign_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             parity_q, parity_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    op_e              op;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH:0]   sum;
    logic             op_ovf;
    logic [WIDTH-1:0] z_new;
    logic             carry_new;
    logic             ovf_new;

    assign in_ready = ~out_vld_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign op       = op_e'(in_op);

    // One shared adder: PASS adds x+y, ACC adds acc+x.
    assign add_a  = (op == OP_PASS) ? in_y : acc_q;
    assign sum    = {1'b0, add_a} + {1'b0, in_x};
    assign op_ovf = (add_a[WIDTH-1] == in_x[WIDTH-1]) & (sum[WIDTH-1] != in_x[WIDTH-1]);

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        z_new     = '0;
        carry_new = 1'b0;
        ovf_new   = 1'b0;
        case (op)
            OP_LOAD: begin
                acc_d = in_x;
                z_new = in_x;
                cnt_d = CNT_W'(1);
            end
            OP_ACC: begin
                acc_d     = sum[WIDTH-1:0];
                z_new     = sum[WIDTH-1:0];
                carry_new = sum[WIDTH];
                ovf_new   = op_ovf;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OP_PASS: begin
                z_new     = sum[WIDTH-1:0];
                carry_new = sum[WIDTH];
                ovf_new   = op_ovf;
            end
            default: begin
                acc_d = '0;
                cnt_d = '0;
            end
        endcase
`ifdef ACC16_STICKY_OVF_EN
        // Sticky overflow survives ACC/PASS; only LOAD/CLEAR (or reset) drop it.
        if (op == OP_ACC || op == OP_PASS) begin
            ovf_new = ovf_new | ovf_q;
        end
`endif
        if (!accept) begin
            acc_d = acc_q;
            cnt_d = cnt_q;
        end
    end

    always_comb begin
        out_vld_d = out_vld_q;
        z_d       = z_q;
        sign_d    = sign_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        parity_d  = parity_q;
        ovf_d     = ovf_q;
        if (accept) begin
            out_vld_d = 1'b1;
            z_d       = z_new;
            sign_d    = z_new[WIDTH-1];
            zero_d    = (z_new == '0);
            carry_d   = carry_new;
            parity_d  = ~^z_new;
            ovf_d     = ovf_new;
        end else if (out_ready) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
            z_q       <= '0;
            sign_q    <= 1'b0;
            zero_q    <= 1'b1;
            carry_q   <= 1'b0;
            parity_q  <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_vld_q <= out_vld_d;
            z_q       <= z_d;
            sign_q    <= sign_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            parity_q  <= parity_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_valid    = out_vld_q;
    assign out_z        = z_q;
    assign out_sign     = sign_q;
    assign out_zero     = zero_q;
    assign out_carry    = carry_q;
    assign out_parity   = parity_q;
    assign out_overflow = ovf_q;
    assign out_cnt      = cnt_q;

endmodule
